kamacore_mem_arbiter: RTL and testbench
=======================================

// Module: kamacore_mem_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF port) and data access (MEM port).
//  Sits between the IF/MEM stages and the memory model.
//  Sequences one outstanding transaction at a time and returns read data to the port that issued it.
//  The IF/MEM stages stall on their own port while it is not granted.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width of both ports and the memory side
//  DATA_WIDTH   32  data width; equals CPU_WIDTH
//  STARVE_LIMIT 4   consecutive MEM grants tolerated while IF waits (starve guard only)
// PORTS
//  clk        in   1             clock; everything is on the rising edge
//  rst        in   1             synchronous reset, active-high
//  if_req     in   1             fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_WIDTH    fetch address
//  if_gnt     out  1             1-cycle pulse: fetch request accepted
//  if_rvalid  out  1             1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_WIDTH    fetched word
//  mem_req    in   1             data request; held with its fields until mem_gnt
//  mem_we     in   1             1 = write, 0 = read
//  mem_be     in   DATA_WIDTH/8  byte enables (writes only)
//  mem_addr   in   ADDR_WIDTH    data address
//  mem_wdata  in   DATA_WIDTH    write data
//  mem_gnt    out  1             1-cycle pulse: data request accepted
//  mem_rvalid out  1             1-cycle pulse: mem_rdata valid (reads only)
//  mem_rdata  out  DATA_WIDTH    load data
//  ram_req    out  1             request to memory; held until ram_ready
//  ram_we / ram_be / ram_addr / ram_wdata  out  (as MEM)  registered copy of the granted request
//  ram_ready  in   1             memory accepts ram_req this cycle
//  ram_rvalid in   1             read data returned, 1-cycle pulse
//  ram_rdata  in   DATA_WIDTH    read data
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, WAIT.
//  - IDLE: if any req is active, pick the winner, pulse its gnt, latch its fields into the ram_* registers,
//    record owner (IF/MEM) and go to ISSUE. With no req, stay in IDLE.
//  - Default priority: MEM beats IF. IF requests always present we=0 and be=all ones.
//  - ISSUE: ram_req=1. On ram_ready: a write goes to IDLE; a read goes to WAIT.
//  - WAIT: on ram_rvalid, pass ram_rdata combinationally to the owner's rdata and pulse its rvalid,
//    then go to IDLE.
//  - Minimum read latency: req@t -> gnt@t, ram_req@t+1 (ready@t+1), rvalid@t+2 at the earliest.
//    A new grant is possible at t+3.
//  - Inactive port: rvalid=0 and rdata=0.
//  - gnt is asserted only in IDLE; a req raised in ISSUE/WAIT waits.
//  - Simultaneous if_req and mem_req: exactly one gnt.
//  - ram_rvalid outside WAIT: dropped, no rvalid pulse (assertion fires in simulation).
//  - Reset value of all outputs and state: 0 / IDLE, owner NONE, starve counter 0.
//  - Reset mid-transaction aborts it. A late ram_rvalid is dropped per the rule above.
//  - Address/data widths pass through unchanged; no alignment checks (MEM stage owns those).
// CONFIGURATION
//  KAMACORE_ARB_STARVE_GUARD_EN defined:
//   - 3-bit counter increments on each MEM grant given while if_req=1.
//   - When count==STARVE_LIMIT, the next arbitration with if_req=1 grants IF and clears the counter.
//   - The counter also clears on any IF grant.
//  Undefined: strict MEM priority, no counter logic.
// STRUCTURE
//  - kamacore_datatypes: add arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT} and
//    arb_owner_e {OWNER_NONE, OWNER_IF, OWNER_MEM}; reuse CPU_WIDTH.
//  - Sub-module kamacore_mem_arb_pick: the winner-select logic plus the starve counter
//    (the counter exists only under the macro).
//  - Top FSM and the ram_* registers live in this module.
// TESTING
//  1 IF-only read: if_req, addr 0x100; ready at once, rvalid next with 0xDEADBEEF
//    -> if_gnt@0, ram_req@1, if_rvalid@2 with if_rdata=0xDEADBEEF; mem_rvalid stays 0.
//  2 Collision: if_req and mem_req (read 0x200) both at cycle 0 -> mem_gnt@0;
//    if_gnt only after mem_rvalid, in the next IDLE.
//  3 Write with ram_ready held low 3 cycles, be=4'b0011
//    -> ram_req stays 1 for 4 cycles with fields stable; back in IDLE after ready; no rvalid on either port.
//  4 Reset asserted in WAIT, then ram_rvalid pulses
//    -> no if_rvalid/mem_rvalid; all outputs 0; the next request is granted normally.
//  5 Guard on, STARVE_LIMIT=4, mem_req and if_req held high continuously
//    -> 4 mem_gnt then 1 if_gnt, repeating. Guard off -> if_gnt never fires.
//  6 Spurious ram_rvalid in IDLE -> both rvalid outputs stay 0; the assertion fires.

Source files
------------

// File: rtl/kamacore_datatypes_pkg.sv
// Shared types for the kamacore memory arbiter: FSM states, transaction owner
// and the starve-counter width. CPU_WIDTH is the core datapath width.
package kamacore_datatypes;

  localparam int CPU_WIDTH    = 32;
  localparam int STARVE_CNT_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_MEM
  } arb_owner_e;

endpackage

// File: rtl/kamacore_mem_arb_pick.sv
// Winner select between the IF and MEM ports. MEM wins by default.
// Optional starve guard (KAMACORE_ARB_STARVE_GUARD_EN): after STARVE_LIMIT
// consecutive MEM grants taken while IF was waiting, IF wins the next
// arbitration in which it requests.
module kamacore_mem_arb_pick
  import kamacore_datatypes::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic mem_req_i,
  output logic if_win_o,
  output logic mem_win_o
);

`ifdef KAMACORE_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    if_starved;

  assign if_starved = (starve_q == LIMIT);

  // Pick the winner and advance the starve counter.
  always_comb begin
    if_win_o  = arb_en_i && if_req_i && (!mem_req_i || if_starved);
    mem_win_o = arb_en_i && mem_req_i && !if_win_o;
    starve_d  = starve_q;
    if (if_win_o)                   starve_d = '0;
    else if (mem_win_o && if_req_i) starve_d = starve_q + 1'b1;
  end

  // Starve counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_pick;
  assign unused_pick = clk_i ^ rst_i;

  // Strict MEM priority.
  always_comb begin
    if_win_o  = arb_en_i && if_req_i && !mem_req_i;
    mem_win_o = arb_en_i && mem_req_i;
  end
`endif

endmodule

// File: rtl/kamacore_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and data
// access (MEM). One transaction in flight; read data is routed back to the
// port that issued it. Optional starve guard: KAMACORE_ARB_STARVE_GUARD_EN.
module kamacore_mem_arbiter
  import kamacore_datatypes::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = CPU_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  output logic                    mem_gnt_o,
  output logic                    mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    ram_req_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic                    ram_ready_i,
  input  logic                    ram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  arb_state_e                state_q, state_d;
  arb_owner_e                owner_q, owner_d;
  logic                      ram_we_q, ram_we_d;
  logic [DATA_WIDTH/8-1:0]   ram_be_q, ram_be_d;
  logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic                      if_win, mem_win;

  kamacore_mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arb_en_i  (state_q == ARB_IDLE),
    .if_req_i  (if_req_i),
    .mem_req_i (mem_req_i),
    .if_win_o  (if_win),
    .mem_win_o (mem_win)
  );

  assign if_gnt_o    = if_win;
  assign mem_gnt_o   = mem_win;
  assign ram_req_o   = (state_q == ARB_ISSUE);
  assign ram_we_o    = ram_we_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

  // Next state, request capture on grant, and read-data routing to the owner.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ram_we_d     = ram_we_q;
    ram_be_d     = ram_be_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_win) begin
          owner_d     = OWNER_MEM;
          ram_we_d    = mem_we_i;
          ram_be_d    = mem_be_i;
          ram_addr_d  = mem_addr_i;
          ram_wdata_d = mem_wdata_i;
          state_d     = ARB_ISSUE;
        end else if (if_win) begin
          // Fetches are always full-word reads.
          owner_d     = OWNER_IF;
          ram_we_d    = 1'b0;
          ram_be_d    = '1;
          ram_addr_d  = if_addr_i;
          ram_wdata_d = '0;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (ram_ready_i) begin
          if (ram_we_q) begin
            state_d = ARB_IDLE;
            owner_d = OWNER_NONE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (ram_rvalid_i) begin
          if (owner_q == OWNER_IF) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = ram_rdata_i;
          end else if (owner_q == OWNER_MEM) begin
            mem_rvalid_o = 1'b1;
            mem_rdata_o  = ram_rdata_i;
          end
          state_d = ARB_IDLE;
          owner_d = OWNER_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  // State, owner and ram_* request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_NONE;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Read data with no transaction waiting for it has no owner and is dropped.
  a_rvalid_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    ram_rvalid_i |-> state_q == ARB_WAIT)
    else $warning("kamacore_mem_arbiter: ram_rvalid outside WAIT dropped");

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Bench for kamacore_mem_arbiter: directed vector table, randomized traffic
// against a transaction-level model, and a starve-guard grant-pattern sequence.
module tb_kamacore_mem_arbiter;

`ifdef KAMACORE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, ram_ready, ram_rvalid;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_be;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_req, ram_we;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_be;

  always #5 clk = ~clk;

  kamacore_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt),
    .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_ready_i(ram_ready), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic rst, ir; logic [31:0] ia;
    logic mr, mw; logic [3:0] mbe; logic [31:0] ma, md;
    logic rdy, rv; logic [31:0] rd;
    logic e_ig, e_mg, e_rr, e_we; logic [3:0] e_be; logic [31:0] e_a, e_wd;
    logic e_iv, e_mv;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, ir, input logic [31:0] ia, input logic mr, mw,
                     input logic [3:0] mbe, input logic [31:0] ma, md,
                     input logic rdy, rv, input logic [31:0] rd,
                     input logic eig, emg, err, ewe, input logic [3:0] ebe,
                     input logic [31:0] ea, ewd, input logic eiv, emv);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.mbe = mbe; v.ma = ma; v.md = md;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_ig = eig; v.e_mg = emg; v.e_rr = err; v.e_we = ewe; v.e_be = ebe; v.e_a = ea; v.e_wd = ewd;
    v.e_iv = eiv; v.e_mv = emv;
    vecs.push_back(v);
  endtask

  // One comparison of every visible output; ram_* fields only while ram_req is expected.
  task automatic check(input string nm, input int idx, input logic e_ig, e_mg, e_rr, e_we,
                       input logic [3:0] e_be, input logic [31:0] e_a, e_wd, input bit cmp_wd,
                       input logic e_iv, input logic [31:0] e_id, input logic e_mv,
                       input logic [31:0] e_md);
    bit bad;
    bad = (if_gnt !== e_ig) || (mem_gnt !== e_mg) || (ram_req !== e_rr) ||
          (if_rvalid !== e_iv) || (if_rdata !== e_id) || (mem_rvalid !== e_mv) || (mem_rdata !== e_md);
    if (e_rr) bad = bad || (ram_we !== e_we) || (ram_be !== e_be) || (ram_addr !== e_a) ||
                    (cmp_wd && (ram_wdata !== e_wd));
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL %s[%0d]: got ig=%b mg=%b rr=%b we=%b be=%h a=%h wd=%h iv=%b id=%h mv=%b md=%h | want ig=%b mg=%b rr=%b we=%b be=%h a=%h wd=%h iv=%b id=%h mv=%b md=%h",
               nm, idx, if_gnt, mem_gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata, if_rvalid,
               if_rdata, mem_rvalid, mem_rdata, e_ig, e_mg, e_rr, e_we, e_be, e_a, e_wd, e_iv,
               e_id, e_mv, e_md);
    end
  endtask

  // Transaction-level reference: at most one granted transaction outstanding.
  bit          m_busy, m_acc, m_own_if, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd;
  int          m_starve, rv_wait;
  bit          if_drop, mem_drop;
  bit          gseq[$];

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_starve = 0; rv_wait = 0; if_drop = 0; mem_drop = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; if_req = 0; mem_req = 0; mem_we = 0; ram_ready = 0; ram_rvalid = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_be = 0; ram_rdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic model_cycle(input bit force_both, input int idx);
    bit e_ig, e_mg, e_rr, e_iv, e_mv;
    @(posedge clk); #1;
    if (if_drop)  begin if_req = 0;  if_drop = 0;  end
    if (mem_drop) begin mem_req = 0; mem_drop = 0; end
    if (!if_req && (force_both || $urandom_range(0, 2) == 0)) begin
      if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!mem_req && (force_both || $urandom_range(0, 2) == 0)) begin
      mem_req = 1; mem_we = force_both ? 1'b1 : 1'($urandom_range(0, 1));
      mem_be = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
    end
    ram_ready  = force_both ? 1'b1 : 1'($urandom_range(0, 1));
    ram_rvalid = m_busy && m_acc && (rv_wait == 0);
    ram_rdata  = $urandom;
    @(negedge clk);
    e_ig = 0; e_mg = 0;
    if (!m_busy && (if_req || mem_req)) begin
      if (mem_req && !(GUARD && if_req && m_starve >= LIMIT)) e_mg = 1;
      else e_ig = 1;
    end
    e_rr = m_busy && !m_acc;
    e_iv = m_busy && m_acc && ram_rvalid && m_own_if;
    e_mv = m_busy && m_acc && ram_rvalid && !m_own_if;
    check("rnd", idx, e_ig, e_mg, e_rr, m_we, m_be, m_addr, m_wd, m_we,
          e_iv, e_iv ? ram_rdata : 32'h0, e_mv, e_mv ? ram_rdata : 32'h0);
    if (if_gnt || mem_gnt) gseq.push_back(if_gnt);
    if (e_ig) begin
      m_busy = 1; m_acc = 0; m_own_if = 1; m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wd = 0;
      m_starve = 0; if_drop = 1;
    end else if (e_mg) begin
      m_busy = 1; m_acc = 0; m_own_if = 0; m_we = mem_we; m_be = mem_be; m_addr = mem_addr;
      m_wd = mem_wdata; mem_drop = 1;
      if (GUARD && if_req) m_starve++;
    end else if (m_busy && !m_acc) begin
      if (ram_ready) begin
        if (m_we) m_busy = 0;
        else begin m_acc = 1; rv_wait = $urandom_range(0, 2); end
      end
    end else if (m_busy && m_acc) begin
      if (ram_rvalid) m_busy = 0;
      else if (rv_wait > 0) rv_wait--;
    end
  endtask

  initial begin
    vec_t v;
    // rst  ir ia           mr mw mbe   ma           md           rdy rv rd            ig mg rr we be    a            wd           iv mv
    add(1, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    // IF-only read
    add(0, 1, 32'h100,     0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        1, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h100,     32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       1, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    // collision: MEM first, IF granted in the IDLE after mem_rvalid
    add(0, 1, 32'h104,     1, 0, 4'hF, 32'h200,     32'h0,       0, 0, 32'h0,        0, 1, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 1, 32'h104,     0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h200,     32'h0,       0, 0);
    add(0, 1, 32'h104,     0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'h12345678, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 1);
    add(0, 1, 32'h104,     0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        1, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h104,     32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       1, 0);
    // write, ready low 3 cycles, be=0011
    add(0, 0, 32'h0,       1, 1, 4'h3, 32'h300,     32'hA5A5A5A5, 0, 0, 32'h0,       0, 1, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 1, 1, 4'h3, 32'h300,     32'hA5A5A5A5, 0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 1, 1, 4'h3, 32'h300,     32'hA5A5A5A5, 0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 1, 1, 4'h3, 32'h300,     32'hA5A5A5A5, 0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 1, 4'h3, 32'h300,     32'hA5A5A5A5, 0, 0);
    add(0, 1, 32'h400,     0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        1, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h400,     32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'h0BADF00D, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       1, 0);
    // spurious ram_rvalid in IDLE
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    // reset in WAIT, late ram_rvalid dropped, next request served normally
    add(0, 0, 32'h0,       1, 0, 4'hF, 32'h500,     32'h0,       0, 0, 32'h0,        0, 1, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h500,     32'h0,       0, 0);
    add(1, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'h55555555, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 1, 32'h600,     0, 0, 4'h0, 32'h0,       32'h0,       0, 0, 32'h0,        1, 0, 0, 0, 4'h0, 32'h0,       32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       1, 0, 32'h0,        0, 0, 1, 0, 4'hF, 32'h600,     32'h0,       0, 0);
    add(0, 0, 32'h0,       0, 0, 4'h0, 32'h0,       32'h0,       0, 1, 32'h11112222, 0, 0, 0, 0, 4'h0, 32'h0,       32'h0,       1, 0);

    do_reset();
    @(negedge clk);
    nvec++;
    if ({ram_req, ram_we, ram_be, ram_addr, ram_wdata} !== 70'h0) begin
      nerr++;
      $display("FAIL reset_fields: got req=%b we=%b be=%h a=%h wd=%h, want all 0",
               ram_req, ram_we, ram_be, ram_addr, ram_wdata);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge clk); #1;
      rst = v.rst; if_req = v.ir; if_addr = v.ia; mem_req = v.mr; mem_we = v.mw; mem_be = v.mbe;
      mem_addr = v.ma; mem_wdata = v.md; ram_ready = v.rdy; ram_rvalid = v.rv; ram_rdata = v.rd;
      @(negedge clk);
      check("tab", i, v.e_ig, v.e_mg, v.e_rr, v.e_we, v.e_be, v.e_a, v.e_wd, v.e_we,
            v.e_iv, v.e_iv ? v.rd : 32'h0, v.e_mv, v.e_mv ? v.rd : 32'h0);
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) model_cycle(1'b0, i);

    // both ports requesting continuously: grant pattern
    do_reset();
    gseq.delete();
    for (int i = 0; i < 100; i++) model_cycle(1'b1, i);
    for (int k = 0; k < 20; k++) begin
      bit want_if;
      want_if = GUARD && (k % (LIMIT + 1) == LIMIT);
      nvec++;
      if (k >= gseq.size()) begin
        nerr++;
        $display("FAIL starve[%0d]: got no grant, want if_gnt=%b", k, want_if);
      end else if (gseq[k] != want_if) begin
        nerr++;
        $display("FAIL starve[%0d]: got if_gnt=%b, want if_gnt=%b", k, gseq[k], want_if);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
